// File: rtl/idex_hazard_stage_pkg.sv
// Shared types and widths for the ID/EX pipeline stage.
package riscv_pipe_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 4;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic    regWrite;
    logic    memRead;
    logic    memWrite;
    logic    memToReg;
    logic    aluSrc;
    logic    branch;
    alu_op_e aluOp;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_CTRL_NOP = '{
    regWrite: 1'b0, memRead: 1'b0, memWrite: 1'b0, memToReg: 1'b0,
    aluSrc: 1'b0, branch: 1'b0, aluOp: ALU_ADD
  };

  // x0 is hardwired to zero, so a write to it never creates a dependency
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
    return addr == REG_ADDR_W'(0);
  endfunction

endpackage

// File: rtl/idex_hazard_stage_if.sv
// Decode-to-execute bus: ID-side inputs, EX-side registered outputs, stall strobes, counters.
interface idex_hazard_stage_if;
  import riscv_pipe_pkg::*;

  logic                  valid_ID;
  logic [REG_ADDR_W-1:0] readReg1_ID;
  logic                  usesRs1_ID;
  logic [REG_ADDR_W-1:0] readReg2_ID;
  logic                  usesRs2_ID;
  logic [REG_ADDR_W-1:0] writeReg_ID;
  idex_ctrl_t            ctrl_ID;
  logic [XLEN-1:0]       rd1_ID;
  logic [XLEN-1:0]       rd2_ID;
  logic [XLEN-1:0]       imm_ID;
  logic [XLEN-1:0]       pc_ID;
  logic                  flush_EX;
  logic                  hold;

  logic                  valid_EX;
  logic [REG_ADDR_W-1:0] readReg1_EX;
  logic [REG_ADDR_W-1:0] readReg2_EX;
  logic [REG_ADDR_W-1:0] writeReg_EX;
  idex_ctrl_t            ctrl_EX;
  logic [XLEN-1:0]       rd1_EX;
  logic [XLEN-1:0]       rd2_EX;
  logic [XLEN-1:0]       imm_EX;
  logic [XLEN-1:0]       pc_EX;
  logic                  pcWrite;
  logic                  ifidWrite;
  logic [CNT_W-1:0]      stallCount;
  logic [CNT_W-1:0]      flushCount;

  modport master (
    output valid_ID, readReg1_ID, usesRs1_ID, readReg2_ID, usesRs2_ID, writeReg_ID,
           ctrl_ID, rd1_ID, rd2_ID, imm_ID, pc_ID, flush_EX, hold,
    input  valid_EX, readReg1_EX, readReg2_EX, writeReg_EX, ctrl_EX,
           rd1_EX, rd2_EX, imm_EX, pc_EX, pcWrite, ifidWrite, stallCount, flushCount
  );

  modport slave (
    input  valid_ID, readReg1_ID, usesRs1_ID, readReg2_ID, usesRs2_ID, writeReg_ID,
           ctrl_ID, rd1_ID, rd2_ID, imm_ID, pc_ID, flush_EX, hold,
    output valid_EX, readReg1_EX, readReg2_EX, writeReg_EX, ctrl_EX,
           rd1_EX, rd2_EX, imm_EX, pc_EX, pcWrite, ifidWrite, stallCount, flushCount
  );

endinterface

// File: rtl/idex_hazard_stage_load_use_detect.sv
// Load-use detector: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import riscv_pipe_pkg::*;
(
  input  logic                  valid_ex,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] write_reg_ex,
  input  logic                  valid_id,
  input  logic [REG_ADDR_W-1:0] read_reg1_id,
  input  logic                  uses_rs1_id,
  input  logic [REG_ADDR_W-1:0] read_reg2_id,
  input  logic                  uses_rs2_id,
  output logic                  load_use_c
);

  // Only operands that are actually read can create a dependency
  always_comb begin
    load_use_c = 1'b0;
    if (valid_ex && mem_read_ex && !is_x0(write_reg_ex) && valid_id) begin
      load_use_c = (uses_rs1_id && (read_reg1_id == write_reg_ex)) ||
                   (uses_rs2_id && (read_reg2_id == write_reg_ex));
    end
  end

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and global hold.
// Optional build macro IDEX_PERF_CNT_EN adds stall/flush performance counters.
module idex_hazard_stage
  import riscv_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  idex_hazard_stage_if.slave bus
);

  logic                  load_use_c;
  logic                  stall_c;
  logic                  bubble_c;

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  idex_ctrl_t            ctrl_q;
  logic [XLEN-1:0]       rd1_q;
  logic [XLEN-1:0]       rd2_q;
  logic [XLEN-1:0]       imm_q;
  logic [XLEN-1:0]       pc_q;

  load_use_detect u_load_use_detect (
    .valid_ex     (valid_q),
    .mem_read_ex  (ctrl_q.memRead),
    .write_reg_ex (rd_q),
    .valid_id     (bus.valid_ID),
    .read_reg1_id (bus.readReg1_ID),
    .uses_rs1_id  (bus.usesRs1_ID),
    .read_reg2_id (bus.readReg2_ID),
    .uses_rs2_id  (bus.usesRs2_ID),
    .load_use_c   (load_use_c)
  );

  // Flush wins over hold and hazard: the redirect must proceed, so no stall then
  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    if (!bus.flush_EX) begin
      stall_c  = bus.hold || load_use_c;
      bubble_c = !bus.hold && load_use_c;
    end
  end

  assign bus.pcWrite   = ~stall_c;
  assign bus.ifidWrite = ~stall_c;

  // Pipeline register: flush/bubble clear it, hold freezes it, otherwise ID advances
  always_ff @(posedge clk) begin
    if (reset || bus.flush_EX || bubble_c) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= IDEX_CTRL_NOP;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else if (!bus.hold) begin
      valid_q <= bus.valid_ID;
      rs1_q   <= bus.readReg1_ID;
      rs2_q   <= bus.readReg2_ID;
      rd_q    <= bus.writeReg_ID;
      ctrl_q  <= bus.valid_ID ? bus.ctrl_ID : IDEX_CTRL_NOP;
      rd1_q   <= bus.rd1_ID;
      rd2_q   <= bus.rd2_ID;
      imm_q   <= bus.imm_ID;
      pc_q    <= bus.pc_ID;
    end
  end

  assign bus.valid_EX    = valid_q;
  assign bus.readReg1_EX = rs1_q;
  assign bus.readReg2_EX = rs2_q;
  assign bus.writeReg_EX = rd_q;
  assign bus.ctrl_EX     = ctrl_q;
  assign bus.rd1_EX      = rd1_q;
  assign bus.rd2_EX      = rd2_q;
  assign bus.imm_EX      = imm_q;
  assign bus.pc_EX       = pc_q;

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Bubbles are counted only when actually inserted; flushes count even under hold
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubble_c) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bus.flush_EX) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stallCount = stall_cnt_q;
  assign bus.flushCount = flush_cnt_q;
`else
  assign bus.stallCount = '0;
  assign bus.flushCount = '0;
`endif

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Scoreboard bench for idex_hazard_stage: expected EX contents are queued per driven cycle.
module tb_idex_hazard_stage;
  import riscv_pipe_pkg::*;

`ifdef IDEX_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [4:0]  r1;
    logic        u1;
    logic [4:0]  r2;
    logic        u2;
    logic [4:0]  wr;
    logic        mr;
    logic        rw;
    logic        mw;
    logic [31:0] pc;
    logic        fl;
    logic        hd;
  } stim_t;

  typedef struct packed {
    logic        valid;
    idex_ctrl_t  ctrl;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
  } ex_t;

  typedef enum int {K_PASS, K_BUB, K_FLUSH, K_HOLD} kind_e;

  logic clk;
  logic reset;
  idex_hazard_stage_if bus ();

  idex_hazard_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  ex_t         sb[$];
  logic        strb_q[$];
  ex_t         last_ex;
  logic [31:0] exp_stall;
  logic [31:0] exp_flush;

  function automatic stim_t st(input logic v, input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2, input logic [4:0] wr,
                               input logic mr, input logic rw, input logic mw,
                               input logic [31:0] pc, input logic fl, input logic hd);
    stim_t s;
    s.v = v; s.r1 = r1; s.u1 = u1; s.r2 = r2; s.u2 = u2; s.wr = wr;
    s.mr = mr; s.rw = rw; s.mw = mw; s.pc = pc; s.fl = fl; s.hd = hd;
    return s;
  endfunction

  function automatic idex_ctrl_t mk_ctrl(input stim_t s);
    idex_ctrl_t c;
    c = '{regWrite: s.rw, memRead: s.mr, memWrite: s.mw, memToReg: s.mr,
          aluSrc: s.mr | s.mw, branch: 1'b0, aluOp: ALU_ADD};
    return c;
  endfunction

  function automatic ex_t cur_ex();
    ex_t a;
    a.valid = bus.valid_EX;   a.ctrl = bus.ctrl_EX;
    a.r1 = bus.readReg1_EX;   a.r2 = bus.readReg2_EX; a.wr = bus.writeReg_EX;
    a.rd1 = bus.rd1_EX;       a.rd2 = bus.rd2_EX;
    a.imm = bus.imm_EX;       a.pc = bus.pc_EX;
    return a;
  endfunction

  task automatic drive(input stim_t s);
    bus.valid_ID    = s.v;
    bus.readReg1_ID = s.r1;
    bus.usesRs1_ID  = s.u1;
    bus.readReg2_ID = s.r2;
    bus.usesRs2_ID  = s.u2;
    bus.writeReg_ID = s.wr;
    bus.ctrl_ID     = mk_ctrl(s);
    bus.rd1_ID      = s.pc ^ 32'h1111_0000;
    bus.rd2_ID      = s.pc ^ 32'h0000_2222;
    bus.imm_ID      = s.pc + 32'd4;
    bus.pc_ID       = s.pc;
    bus.flush_EX    = s.fl;
    bus.hold        = s.hd;
  endtask

  // Turn the intended outcome of a cycle into the expected EX contents and strobe
  task automatic push_exp(input stim_t s, input kind_e k);
    ex_t e;
    e = '0;
    case (k)
      K_PASS: begin
        e.valid = s.v;
        e.ctrl  = s.v ? mk_ctrl(s) : IDEX_CTRL_NOP;
        e.r1 = s.r1; e.r2 = s.r2; e.wr = s.wr;
        e.rd1 = s.pc ^ 32'h1111_0000; e.rd2 = s.pc ^ 32'h0000_2222;
        e.imm = s.pc + 32'd4; e.pc = s.pc;
        strb_q.push_back(1'b1);
      end
      K_BUB: begin
        exp_stall = exp_stall + 32'd1;
        strb_q.push_back(1'b0);
      end
      K_FLUSH: strb_q.push_back(1'b1);
      default: begin
        e = last_ex;
        strb_q.push_back(1'b0);
      end
    endcase
    if (s.fl) exp_flush = exp_flush + 32'd1;
    last_ex = e;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cur_ex() !== ex_t'('0)) begin
      failures++;
      $display("FAIL reset_ex got=%h exp=%h", cur_ex(), ex_t'('0));
    end
    checks++;
    if ({bus.pcWrite, bus.ifidWrite, bus.stallCount, bus.flushCount} !== {2'b11, 64'd0}) begin
      failures++;
      $display("FAIL reset_strobe_cnt got=%b%b %0d %0d exp=11 0 0",
               bus.pcWrite, bus.ifidWrite, bus.stallCount, bus.flushCount);
    end
    @(negedge clk);
    reset = 1'b0;
    last_ex = '0; exp_stall = '0; exp_flush = '0;
  endtask

  task automatic test_load_use();
    stim_t rows[$]; kind_e kinds[$]; ex_t e, a; logic es;
    rows.push_back(st(1, 2, 1, 0, 0, 5, 1, 1, 0, 32'h100, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 5, 1, 7, 1, 6, 0, 1, 0, 32'h104, 0, 0)); kinds.push_back(K_BUB);
    rows.push_back(st(1, 5, 1, 7, 1, 6, 0, 1, 0, 32'h104, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));   kinds.push_back(K_PASS);
    foreach (rows[i]) begin
      drive(rows[i]); push_exp(rows[i], kinds[i]);
      #1; es = strb_q.pop_front(); checks++;
      if ({bus.pcWrite, bus.ifidWrite} !== {es, es}) begin
        failures++; $display("FAIL load_use_strobe row%0d got=%b%b exp=%b", i, bus.pcWrite, bus.ifidWrite, es);
      end
      @(posedge clk); #1; e = sb.pop_front(); a = cur_ex(); checks++;
      if (a !== e) begin failures++; $display("FAIL load_use_ex row%0d got=%h exp=%h", i, a, e); end
      @(negedge clk);
    end
    checks++;
    if (bus.stallCount !== (CNT_EN ? exp_stall : 32'd0) || bus.flushCount !== (CNT_EN ? exp_flush : 32'd0)) begin
      failures++; $display("FAIL load_use_cnt got=%0d/%0d", bus.stallCount, bus.flushCount);
    end
  endtask

  task automatic test_no_stall();
    stim_t rows[$]; kind_e kinds[$]; ex_t e, a; logic es;
    rows.push_back(st(1, 2, 1, 0, 0, 0, 1, 1, 0, 32'h200, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 0, 1, 1, 1, 6, 0, 1, 0, 32'h204, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 2, 1, 0, 0, 5, 1, 1, 0, 32'h208, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 3, 1, 5, 0, 8, 0, 1, 0, 32'h20C, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));   kinds.push_back(K_PASS);
    foreach (rows[i]) begin
      drive(rows[i]); push_exp(rows[i], kinds[i]);
      #1; es = strb_q.pop_front(); checks++;
      if ({bus.pcWrite, bus.ifidWrite} !== {es, es}) begin
        failures++; $display("FAIL no_stall_strobe row%0d got=%b%b exp=%b", i, bus.pcWrite, bus.ifidWrite, es);
      end
      @(posedge clk); #1; e = sb.pop_front(); a = cur_ex(); checks++;
      if (a !== e) begin failures++; $display("FAIL no_stall_ex row%0d got=%h exp=%h", i, a, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    stim_t rows[$]; kind_e kinds[$]; ex_t e, a; logic es;
    rows.push_back(st(1, 2, 1, 0, 0, 5, 1, 1, 0, 32'h300, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 5, 1, 7, 1, 6, 0, 1, 0, 32'h304, 1, 0)); kinds.push_back(K_FLUSH);
    rows.push_back(st(1, 5, 1, 1, 1, 9, 0, 1, 0, 32'h400, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));   kinds.push_back(K_PASS);
    foreach (rows[i]) begin
      drive(rows[i]); push_exp(rows[i], kinds[i]);
      #1; es = strb_q.pop_front(); checks++;
      if ({bus.pcWrite, bus.ifidWrite} !== {es, es}) begin
        failures++; $display("FAIL flush_strobe row%0d got=%b%b exp=%b", i, bus.pcWrite, bus.ifidWrite, es);
      end
      @(posedge clk); #1; e = sb.pop_front(); a = cur_ex(); checks++;
      if (a !== e) begin failures++; $display("FAIL flush_ex row%0d got=%h exp=%h", i, a, e); end
      @(negedge clk);
    end
    checks++;
    if (bus.stallCount !== (CNT_EN ? exp_stall : 32'd0) || bus.flushCount !== (CNT_EN ? exp_flush : 32'd0)) begin
      failures++; $display("FAIL flush_cnt got=%0d/%0d", bus.stallCount, bus.flushCount);
    end
  endtask

  task automatic test_hold();
    stim_t rows[$]; kind_e kinds[$]; ex_t e, a; logic es;
    rows.push_back(st(1, 2, 1, 0, 0, 1, 0, 1, 0, 32'h500, 0, 0)); kinds.push_back(K_PASS);
    for (int k = 0; k < 3; k++) begin
      rows.push_back(st(1, 3, 1, 0, 0, 4, 0, 1, 0, 32'h504, 0, 1)); kinds.push_back(K_HOLD);
    end
    rows.push_back(st(1, 3, 1, 0, 0, 4, 0, 1, 0, 32'h504, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 2, 1, 0, 0, 5, 1, 1, 0, 32'h508, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 5, 1, 0, 0, 7, 0, 1, 0, 32'h50C, 0, 1)); kinds.push_back(K_HOLD);
    rows.push_back(st(1, 5, 1, 0, 0, 7, 0, 1, 0, 32'h50C, 0, 0)); kinds.push_back(K_BUB);
    rows.push_back(st(1, 5, 1, 0, 0, 7, 0, 1, 0, 32'h50C, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 1, 1, 0, 0, 3, 0, 1, 0, 32'h510, 1, 1)); kinds.push_back(K_FLUSH);
    rows.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));   kinds.push_back(K_PASS);
    foreach (rows[i]) begin
      drive(rows[i]); push_exp(rows[i], kinds[i]);
      #1; es = strb_q.pop_front(); checks++;
      if ({bus.pcWrite, bus.ifidWrite} !== {es, es}) begin
        failures++; $display("FAIL hold_strobe row%0d got=%b%b exp=%b", i, bus.pcWrite, bus.ifidWrite, es);
      end
      @(posedge clk); #1; e = sb.pop_front(); a = cur_ex(); checks++;
      if (a !== e) begin failures++; $display("FAIL hold_ex row%0d got=%h exp=%h", i, a, e); end
      @(negedge clk);
    end
    checks++;
    if (bus.stallCount !== (CNT_EN ? exp_stall : 32'd0) || bus.flushCount !== (CNT_EN ? exp_flush : 32'd0)) begin
      failures++; $display("FAIL hold_cnt got=%0d/%0d", bus.stallCount, bus.flushCount);
    end
  endtask

  task automatic test_back_to_back();
    stim_t rows[$]; kind_e kinds[$]; ex_t e, a; logic es;
    rows.push_back(st(1, 2, 1, 0, 0, 5, 1, 1, 0, 32'h600, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 5, 1, 0, 0, 6, 1, 1, 0, 32'h604, 0, 0)); kinds.push_back(K_BUB);
    rows.push_back(st(1, 5, 1, 0, 0, 6, 1, 1, 0, 32'h604, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 2, 1, 6, 1, 0, 0, 0, 1, 32'h608, 0, 0)); kinds.push_back(K_BUB);
    rows.push_back(st(1, 2, 1, 6, 1, 0, 0, 0, 1, 32'h608, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));   kinds.push_back(K_PASS);
    foreach (rows[i]) begin
      drive(rows[i]); push_exp(rows[i], kinds[i]);
      #1; es = strb_q.pop_front(); checks++;
      if ({bus.pcWrite, bus.ifidWrite} !== {es, es}) begin
        failures++; $display("FAIL b2b_strobe row%0d got=%b%b exp=%b", i, bus.pcWrite, bus.ifidWrite, es);
      end
      @(posedge clk); #1; e = sb.pop_front(); a = cur_ex(); checks++;
      if (a !== e) begin failures++; $display("FAIL b2b_ex row%0d got=%h exp=%h", i, a, e); end
      @(negedge clk);
    end
    checks++;
    if (bus.stallCount !== (CNT_EN ? exp_stall : 32'd0) || bus.flushCount !== (CNT_EN ? exp_flush : 32'd0)) begin
      failures++; $display("FAIL b2b_cnt got=%0d/%0d", bus.stallCount, bus.flushCount);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(st(1, 2, 1, 0, 0, 5, 1, 1, 0, 32'h700, 0, 0));
    @(posedge clk); @(negedge clk);
    drive(st(1, 5, 1, 0, 0, 6, 0, 1, 0, 32'h704, 0, 0));
    #1; checks++;
    if ({bus.pcWrite, bus.ifidWrite} !== 2'b00) begin
      failures++; $display("FAIL rst_stall_pending got=%b%b exp=00", bus.pcWrite, bus.ifidWrite);
    end
    reset = 1'b1;
    @(posedge clk); #1; checks++;
    if (cur_ex() !== ex_t'('0)) begin
      failures++; $display("FAIL rst_stall_ex got=%h exp=%h", cur_ex(), ex_t'('0));
    end
    checks++;
    if ({bus.pcWrite, bus.ifidWrite, bus.stallCount, bus.flushCount} !== {2'b11, 64'd0}) begin
      failures++; $display("FAIL rst_stall_strobe_cnt got=%b%b %0d %0d exp=11 0 0",
                           bus.pcWrite, bus.ifidWrite, bus.stallCount, bus.flushCount);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    last_ex = '0; exp_stall = '0; exp_flush = '0;
  endtask

`ifdef IDEX_PERF_CNT_EN
  task automatic test_wrap();
    stim_t rows[$]; kind_e kinds[$]; ex_t e, a; logic es;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    exp_stall = 32'hFFFF_FFFF;
    rows.push_back(st(1, 2, 1, 0, 0, 5, 1, 1, 0, 32'h800, 0, 0)); kinds.push_back(K_PASS);
    rows.push_back(st(1, 5, 1, 0, 0, 6, 0, 1, 0, 32'h804, 0, 0)); kinds.push_back(K_BUB);
    foreach (rows[i]) begin
      drive(rows[i]); push_exp(rows[i], kinds[i]);
      #1; es = strb_q.pop_front(); checks++;
      if ({bus.pcWrite, bus.ifidWrite} !== {es, es}) begin
        failures++; $display("FAIL wrap_strobe row%0d got=%b%b exp=%b", i, bus.pcWrite, bus.ifidWrite, es);
      end
      @(posedge clk); #1; e = sb.pop_front(); a = cur_ex(); checks++;
      if (a !== e) begin failures++; $display("FAIL wrap_ex row%0d got=%h exp=%h", i, a, e); end
      @(negedge clk);
    end
    checks++;
    if (bus.stallCount !== exp_stall) begin
      failures++; $display("FAIL wrap_cnt got=%h exp=%h", bus.stallCount, exp_stall);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    last_ex = '0; exp_stall = '0; exp_flush = '0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_stall();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef IDEX_PERF_CNT_EN
    test_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
